// File: rtl/stage_id_buf.sv
// Instruction queue between fetch and decode, followed by a registered decode stage.
// Optional build macro STAGE_ID_BYPASS_EN lets a push into an empty queue load the output stage directly.
module stage_id_buf #(
    parameter int DEPTH      = 4,
    parameter int INST_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    localparam int ALU_SRC_W = 2,
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INST_W-1:0]     in_inst,
    input  logic [ADDR_W-1:0]     in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] regfile_addr1,
    output logic [REG_ADDR_W-1:0] regfile_addr2,
    output logic                  out_is_load,
    output logic                  out_is_store,
    output logic                  out_is_atomic,
    output logic                  out_is_branch,
    output logic                  out_is_jump,
    output logic                  out_is_jal,
    output logic                  out_reg_wr,
    output logic [REG_ADDR_W-1:0] out_reg_addr_rd,
    output logic [REG_ADDR_W-1:0] out_reg_addr_r1,
    output logic [REG_ADDR_W-1:0] out_reg_addr_r2,
    output logic [3:0]            out_alu_op,
    output logic [ALU_SRC_W-1:0]  out_alu_src_arg1,
    output logic [ALU_SRC_W-1:0]  out_alu_src_arg2,
    output logic [DATA_W-1:0]     out_imm,
    output logic [2:0]            out_branch_type,
    output logic [ADDR_W-1:0]     out_pc,
    output logic [CNT_W-1:0]      count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [3:0] ALU_OP_ADD = 4'b0000;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_ALUR   = 7'b0110011,
        OP_ALUI   = 7'b0010011,
        OP_AMO    = 7'b0101111
    } opcode_e;

    typedef enum logic [ALU_SRC_W-1:0] {
        SRC_REG = 2'd0,
        SRC_PC  = 2'd1,
        SRC_IMM = 2'd2
    } alu_src_e;

    typedef struct packed {
        logic                  is_load;
        logic                  is_store;
        logic                  is_atomic;
        logic                  is_branch;
        logic                  is_jump;
        logic                  is_jal;
        logic                  reg_wr;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] r1;
        logic [REG_ADDR_W-1:0] r2;
        logic [3:0]            alu_op;
        logic [ALU_SRC_W-1:0]  src1;
        logic [ALU_SRC_W-1:0]  src2;
        logic [DATA_W-1:0]     imm;
        logic [2:0]            branch_type;
        logic [ADDR_W-1:0]     pc;
    } dec_t;

    // JAL and JALR both belong to the jump class; is_jal tells them apart.
    function automatic dec_t decode(input logic [INST_W-1:0] inst, input logic [ADDR_W-1:0] pc);
        dec_t       d;
        logic       wr;
        logic [2:0] f3;
        f3            = inst[14:12];
        wr            = 1'b0;
        d             = '0;
        d.rd          = REG_ADDR_W'(inst[11:7]);
        d.r1          = REG_ADDR_W'(inst[19:15]);
        d.r2          = REG_ADDR_W'(inst[24:20]);
        d.branch_type = f3;
        d.pc          = pc;
        d.alu_op      = ALU_OP_ADD;
        d.src1        = SRC_REG;
        d.src2        = SRC_REG;
        case (inst[6:0])
            OP_LOAD: begin
                d.is_load = 1'b1;
                wr        = 1'b1;
                d.src2    = SRC_IMM;
                d.imm     = {{(DATA_W-11){inst[31]}}, inst[30:20]};
            end
            OP_STORE: begin
                d.is_store = 1'b1;
                d.src2     = SRC_IMM;
                d.imm      = {{(DATA_W-11){inst[31]}}, inst[30:25], inst[11:7]};
            end
            OP_LUI: begin
                wr     = 1'b1;
                d.r1   = '0;
                d.src2 = SRC_IMM;
                d.imm  = {{(DATA_W-31){inst[31]}}, inst[30:12], 12'd0};
            end
            OP_AUIPC: begin
                wr     = 1'b1;
                d.r1   = '0;
                d.src1 = SRC_PC;
                d.src2 = SRC_IMM;
                d.imm  = {{(DATA_W-31){inst[31]}}, inst[30:12], 12'd0};
            end
            OP_BRANCH: begin
                d.is_branch = 1'b1;
                d.imm = {{(DATA_W-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OP_JALR: begin
                d.is_jump = 1'b1;
                wr        = 1'b1;
                d.src2    = SRC_IMM;
                d.imm     = {{(DATA_W-11){inst[31]}}, inst[30:20]};
            end
            OP_JAL: begin
                d.is_jump = 1'b1;
                d.is_jal  = 1'b1;
                wr        = 1'b1;
                d.r1      = '0;
                d.src1    = SRC_PC;
                d.src2    = SRC_IMM;
                d.imm = {{(DATA_W-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OP_ALUR: begin
                wr       = 1'b1;
                d.alu_op = {inst[30], f3};
            end
            OP_ALUI: begin
                wr       = 1'b1;
                d.src2   = SRC_IMM;
                d.alu_op = {inst[30] & (f3 == 3'b101), f3};
                d.imm    = {{(DATA_W-11){inst[31]}}, inst[30:20]};
            end
            OP_AMO: begin
                // LR.W is an atomic load, SC.W an atomic store; other AMOs are not decoded
                if (inst[31:27] == 5'b00010) begin
                    d.is_load   = 1'b1;
                    d.is_atomic = 1'b1;
                    wr          = 1'b1;
                    d.src2      = SRC_IMM;
                end else if (inst[31:27] == 5'b00011) begin
                    d.is_store  = 1'b1;
                    d.is_atomic = 1'b1;
                    d.src2      = SRC_IMM;
                end
            end
            default: ;
        endcase
        d.reg_wr = wr && (inst[11:7] != 5'd0);
        return d;
    endfunction

    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              out_valid_q, out_valid_d;
    dec_t              out_q, out_d, sel_dec;
    logic              push, q_push, pop, load_ok, bypass;

    assign in_ready = (count_q != FULL);
    assign push     = in_valid && in_ready && !flush;
    assign load_ok  = !out_valid_q || out_ready;
    assign pop      = load_ok && (count_q != '0) && !flush;
`ifdef STAGE_ID_BYPASS_EN
    assign bypass  = load_ok && (count_q == '0) && push;
    assign sel_dec = (count_q == '0) ? decode(in_inst, in_pc)
                                     : decode(inst_mem_q[rd_ptr_q], pc_mem_q[rd_ptr_q]);
`else
    assign bypass  = 1'b0;
    assign sel_dec = decode(inst_mem_q[rd_ptr_q], pc_mem_q[rd_ptr_q]);
`endif
    assign q_push = push && !bypass;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (q_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(q_push) - CNT_W'(pop);
            if (pop || bypass) begin
                out_valid_d = 1'b1;
                out_d       = sel_dec;
            end else if (load_ok) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (q_push) begin
            inst_mem_q[wr_ptr_q] <= in_inst;
            pc_mem_q[wr_ptr_q]   <= in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign count            = count_q;
    assign out_valid        = out_valid_q;
    assign regfile_addr1    = sel_dec.r1;
    assign regfile_addr2    = sel_dec.r2;
    assign out_is_load      = out_q.is_load;
    assign out_is_store     = out_q.is_store;
    assign out_is_atomic    = out_q.is_atomic;
    assign out_is_branch    = out_q.is_branch;
    assign out_is_jump      = out_q.is_jump;
    assign out_is_jal       = out_q.is_jal;
    assign out_reg_wr       = out_q.reg_wr;
    assign out_reg_addr_rd  = out_q.rd;
    assign out_reg_addr_r1  = out_q.r1;
    assign out_reg_addr_r2  = out_q.r2;
    assign out_alu_op       = out_q.alu_op;
    assign out_alu_src_arg1 = out_q.src1;
    assign out_alu_src_arg2 = out_q.src2;
    assign out_imm          = out_q.imm;
    assign out_branch_type  = out_q.branch_type;
    assign out_pc           = out_q.pc;
endmodule

// File: tb/tb_stage_id_buf.sv
// Randomized bench for stage_id_buf against a queue-based reference model.
// Build with STAGE_ID_BYPASS_EN defined to exercise the bypass variant.
module tb_stage_id_buf;
    localparam int DEPTH = 4;
`ifdef STAGE_ID_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_inst, in_pc, out_imm, out_pc;
    logic [4:0]  regfile_addr1, regfile_addr2, out_reg_addr_rd, out_reg_addr_r1, out_reg_addr_r2;
    logic        out_is_load, out_is_store, out_is_atomic, out_is_branch, out_is_jump, out_is_jal;
    logic        out_reg_wr;
    logic [3:0]  out_alu_op;
    logic [1:0]  out_alu_src_arg1, out_alu_src_arg2;
    logic [2:0]  out_branch_type;
    logic [2:0]  count;

    stage_id_buf #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .regfile_addr1(regfile_addr1), .regfile_addr2(regfile_addr2),
        .out_is_load(out_is_load), .out_is_store(out_is_store), .out_is_atomic(out_is_atomic),
        .out_is_branch(out_is_branch), .out_is_jump(out_is_jump), .out_is_jal(out_is_jal),
        .out_reg_wr(out_reg_wr), .out_reg_addr_rd(out_reg_addr_rd),
        .out_reg_addr_r1(out_reg_addr_r1), .out_reg_addr_r2(out_reg_addr_r2),
        .out_alu_op(out_alu_op), .out_alu_src_arg1(out_alu_src_arg1),
        .out_alu_src_arg2(out_alu_src_arg2), .out_imm(out_imm),
        .out_branch_type(out_branch_type), .out_pc(out_pc), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ld, st, at, br, jmp, jal, wr;
        logic [4:0]  rd, r1, r2;
        logic [3:0]  op;
        logic [1:0]  s1, s2;
        logic [31:0] imm;
        logic [2:0]  bt;
    } exp_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    ent_t        m_ob;
    logic        m_ov;
    logic [31:0] pc_next;
    logic        last_acc;
    int          total, bad;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference decode written from the instruction-format rules with integer arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] i);
        exp_t e;
        int   si;
        int   imm_i, imm_s, imm_b, imm_u, imm_j;
        logic writes;
        si    = $signed(i);
        imm_i = si >>> 20;
        imm_s = ((si >>> 25) << 5) | int'(i[11:7]);
        imm_b = ((si >>> 31) << 12) | (int'(i[7]) << 11) | (int'(i[30:25]) << 5) | (int'(i[11:8]) << 1);
        imm_u = int'(i & 32'hFFFF_F000);
        imm_j = ((si >>> 31) << 20) | (int'(i[19:12]) << 12) | (int'(i[20]) << 11) | (int'(i[30:21]) << 1);
        e = '0;
        writes = 1'b0;
        e.rd = i[11:7];
        e.r1 = i[19:15];
        e.r2 = i[24:20];
        e.bt = i[14:12];
        case (i[6:0])
            7'h03: begin e.ld = 1; writes = 1; e.s2 = 2; e.imm = imm_i; end
            7'h23: begin e.st = 1; e.s2 = 2; e.imm = imm_s; end
            7'h37: begin writes = 1; e.r1 = 0; e.s2 = 2; e.imm = imm_u; end
            7'h17: begin writes = 1; e.r1 = 0; e.s1 = 1; e.s2 = 2; e.imm = imm_u; end
            7'h63: begin e.br = 1; e.imm = imm_b; end
            7'h67: begin e.jmp = 1; writes = 1; e.s2 = 2; e.imm = imm_i; end
            7'h6F: begin e.jmp = 1; e.jal = 1; writes = 1; e.r1 = 0; e.s1 = 1; e.s2 = 2; e.imm = imm_j; end
            7'h33: begin writes = 1; e.op = {i[30], i[14:12]}; end
            7'h13: begin
                writes = 1; e.s2 = 2; e.imm = imm_i;
                e.op = (i[14:12] == 3'd5) ? {i[30], i[14:12]} : {1'b0, i[14:12]};
            end
            7'h2F: begin
                if (i[31:27] == 5'd2) begin e.ld = 1; e.at = 1; writes = 1; e.s2 = 2; end
                else if (i[31:27] == 5'd3) begin e.st = 1; e.at = 1; e.s2 = 2; end
            end
            default: ;
        endcase
        e.wr = writes && (i[11:7] != 0);
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        logic [6:0]  op;
        r = $urandom;
        case ($urandom % 12)
            0: op = 7'h03;  1: op = 7'h23;  2: op = 7'h37;  3: op = 7'h17;
            4: op = 7'h63;  5: op = 7'h67;  6: op = 7'h6F;  7: op = 7'h33;
            8: op = 7'h13;  9: op = 7'h2F;  10: op = 7'h7F; default: op = 7'h0F;
        endcase
        r[6:0] = op;
        if (op == 7'h2F) begin
            case ($urandom % 3)
                0: r[31:27] = 5'd2;
                1: r[31:27] = 5'd3;
                default: r[31:27] = 5'd1;
            endcase
        end
        return r;
    endfunction

    task automatic check_outputs();
        exp_t e;
        check("count", 64'(count), 64'(mq.size()));
        check("in_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
        check("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            e = ref_decode(m_ob.inst);
            check("pc", 64'(out_pc), 64'(m_ob.pc));
            check("is_load", 64'(out_is_load), 64'(e.ld));
            check("is_store", 64'(out_is_store), 64'(e.st));
            check("is_atomic", 64'(out_is_atomic), 64'(e.at));
            check("is_branch", 64'(out_is_branch), 64'(e.br));
            check("is_jump", 64'(out_is_jump), 64'(e.jmp));
            check("is_jal", 64'(out_is_jal), 64'(e.jal));
            check("reg_wr", 64'(out_reg_wr), 64'(e.wr));
            check("rd", 64'(out_reg_addr_rd), 64'(e.rd));
            check("r1", 64'(out_reg_addr_r1), 64'(e.r1));
            check("r2", 64'(out_reg_addr_r2), 64'(e.r2));
            check("alu_op", 64'(out_alu_op), 64'(e.op));
            check("src1", 64'(out_alu_src_arg1), 64'(e.s1));
            check("src2", 64'(out_alu_src_arg2), 64'(e.s2));
            check("imm", 64'(out_imm), 64'(e.imm));
            check("btype", 64'(out_branch_type), 64'(e.bt));
        end
        if (mq.size() > 0) begin
            e = ref_decode(mq[0].inst);
            check("rf_addr1", 64'(regfile_addr1), 64'(e.r1));
            check("rf_addr2", 64'(regfile_addr2), 64'(e.r2));
        end
    endtask

    // One clock: check the state left by the previous edge, drive inputs, advance the model.
    task automatic step(input logic v, input logic [31:0] inst, input logic rdy, input logic fl);
        logic push, consumed, load_ok;
        @(negedge clk);
        check_outputs();
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc_next;
        out_ready = rdy;
        flush     = fl;
        push      = v && (mq.size() != DEPTH) && !fl;
        consumed  = 1'b0;
        if (fl) begin
            mq.delete();
            m_ov = 1'b0;
        end else begin
            load_ok = !m_ov || rdy;
            if (load_ok && mq.size() > 0) begin
                m_ob = mq.pop_front();
                m_ov = 1'b1;
            end
`ifdef STAGE_ID_BYPASS_EN
            else if (load_ok && push) begin
                m_ob = '{inst, pc_next};
                m_ov = 1'b1;
                consumed = 1'b1;
            end
`endif
            else if (load_ok) begin
                m_ov = 1'b0;
            end
            if (push && !consumed) mq.push_back('{inst, pc_next});
        end
        last_acc = push;
        if (push) pc_next = pc_next + 32'd4;
    endtask

    task automatic push_and_watch(input string tag, input logic [31:0] inst, input logic [31:0] eimm,
                                  input logic ewr, input logic ejal, input logic [1:0] es1);
        logic [31:0] mypc;
        logic        found;
        mypc  = pc_next;
        found = 1'b0;
        step(1'b1, inst, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (!found && out_valid && out_pc == mypc) begin
                found = 1'b1;
                check({tag, "_lat"}, 64'(k), 64'(LAT));
                check({tag, "_imm"}, 64'(out_imm), 64'(eimm));
                check({tag, "_wr"}, 64'(out_reg_wr), 64'(ewr));
                check({tag, "_jal"}, 64'(out_is_jal), 64'(ejal));
                check({tag, "_src1"}, 64'(out_alu_src_arg1), 64'(es1));
            end
            step(1'b0, 32'd0, 1'b1, 1'b0);
        end
        if (!found) check({tag, "_seen"}, 64'd0, 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pending;
        total = 0; bad = 0;
        rst_n = 1'b0; flush = 0; in_valid = 0; in_inst = 0; in_pc = 0; out_ready = 0;
        mq.delete(); m_ov = 0; m_ob = '0; pc_next = 0; last_acc = 0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_imm", 64'(out_imm), 64'd0);
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_reg_wr", 64'(out_reg_wr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        push_and_watch("addi", 32'h0050_0093, 32'd5, 1'b1, 1'b0, 2'd0);
        push_and_watch("jal", 32'hFF9F_F06F, 32'hFFFF_FFF8, 1'b0, 1'b1, 2'd1);
        push_and_watch("auipc", 32'h0000_1297, 32'h0000_1000, 1'b1, 1'b0, 2'd1);
        push_and_watch("beq", 32'hFE20_88E3, 32'hFFFF_FFF0, 1'b0, 1'b0, 2'd0);
        push_and_watch("sw", 32'h0020_A423, 32'd8, 1'b0, 1'b0, 2'd0);
        push_and_watch("lw", 32'h0040_A183, 32'd4, 1'b1, 1'b0, 2'd0);

        // LW, SW, BEQ back to back
        step(1'b1, 32'h0040_A183, 1'b1, 1'b0);
        step(1'b1, 32'h0020_A423, 1'b1, 1'b0);
        step(1'b1, 32'hFE20_88E3, 1'b1, 1'b0);
        repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0);

        // stall: output holds one, queue fills to DEPTH
        pending = rand_inst();
        repeat (7) begin
            step(1'b1, pending, 1'b0, 1'b0);
            if (last_acc) pending = rand_inst();
        end
        @(posedge clk);
        #1;
        check("full_count", 64'(count), 64'(DEPTH));
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        repeat (8) step(1'b0, 32'd0, 1'b1, 1'b0);

        // flush with count=3 and a concurrent push
        for (int i = 0; i < 10 && !(mq.size() == 3 && m_ov); i++) begin
            step(1'b1, pending, 1'b0, 1'b0);
            if (last_acc) pending = rand_inst();
        end
        step(1'b1, pending, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            step(($urandom % 4) != 0, pending, ($urandom % 3) != 0, ($urandom % 40) == 0);
            if (last_acc) pending = rand_inst();
        end

        // asynchronous reset while holding count=2
        for (int i = 0; i < 10 && !(mq.size() == 2 && m_ov); i++) begin
            step(1'b1, pending, 1'b0, 1'b0);
            if (last_acc) pending = rand_inst();
        end
        @(negedge clk);
        check_outputs();
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_out_valid", 64'(out_valid), 64'd0);
        mq.delete(); m_ov = 0; pc_next = 0;
        @(negedge clk);
        rst_n = 1'b1;
        push_and_watch("post_rst", 32'h0050_0093, 32'd5, 1'b1, 1'b0, 2'd0);
        step(1'b0, 32'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
